// File: rtl/eea_datapath.sv
// Datapath and sequencer for GF(2^m) inversion by the binary extended Euclidean algorithm.
// Optional macro EEA_ZERO_CHECK_EN: a zero operand skips the iterations and raises err.
module eea_datapath #(
    parameter int m    = 7,
    parameter int BITS = $clog2(2*m+1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [m-1:0] a_in,
    input  logic [m:0]   f_in,
    input  logic         switch_i,
    input  logic         reduce_i,
    input  logic         multr_i,
    input  logic         multu_i,
    output logic         rm,
    output logic         sm,
    output logic         busy,
    output logic         done,
    output logic [m-1:0] result,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, EVAL, APPLY, DONE} state_t;

    state_t         state_q, state_d;
    logic [m:0]     r_q, s_q;
    logic [m-1:0]   u_q, v_q, f_q;
    logic [BITS-1:0] cnt_q;

    logic [m:0]     r_red, s_red, r_nx, s_nx;
    logic [m-1:0]   v_red, u_sw, v_nx, u_nx, u_xf;
    logic           last, go_done;

    assign rm   = r_q[m];
    assign sm   = s_q[m];
    assign busy = (state_q == EVAL) || (state_q == APPLY);
    assign last = (cnt_q == BITS'(2*m-1));

`ifdef EEA_ZERO_CHECK_EN
    assign go_done = (a_in == '0);
`else
    assign go_done = 1'b0;
    assign err     = 1'b0;
`endif

    // One iteration step: reduce, shift, optional swap, then U scaled by x or 1/x.
    always_comb begin
        r_red = r_q;
        s_red = s_q;
        v_red = v_q;
        if (reduce_i) begin
            s_red = s_q ^ r_q;
            v_red = v_q ^ u_q;
        end
        if (multr_i) r_red = {r_red[m-1:0], 1'b0};
        else         s_red = {s_red[m-1:0], 1'b0};

        r_nx = r_red;
        s_nx = s_red;
        u_sw = u_q;
        v_nx = v_red;
        if (switch_i) begin
            r_nx = s_red;
            s_nx = r_red;
            u_sw = v_red;
            v_nx = u_q;
        end

        // F[0]=1 guarantees u_xf[0]=0 when U is odd, so the shift is exact.
        u_xf = u_sw ^ f_q;
        if (multu_i)
            u_nx = {u_sw[m-2:0], 1'b0} ^ (u_sw[m-1] ? f_q : '0);
        else if (u_sw[0])
            u_nx = {1'b1, u_xf[m-1:1]};
        else
            u_nx = {1'b0, u_sw[m-1:1]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = go_done ? DONE : EVAL;
            EVAL:    state_d = APPLY;
            APPLY:   state_d = last ? DONE : EVAL;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            s_q    <= '0;
            u_q    <= '0;
            v_q    <= '0;
            f_q    <= '0;
            cnt_q  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    r_q   <= {1'b0, a_in};
                    s_q   <= f_in;
                    f_q   <= f_in[m-1:0];
                    u_q   <= go_done ? '0 : {{(m-1){1'b0}}, 1'b1};
                    v_q   <= '0;
                    cnt_q <= '0;
                end
                APPLY: begin
                    r_q   <= r_nx;
                    s_q   <= s_nx;
                    u_q   <= u_nx;
                    v_q   <= v_nx;
                    cnt_q <= cnt_q + BITS'(1);
                end
                DONE: begin
                    done   <= 1'b1;
                    result <= u_q;
                end
                default: ;
            endcase
        end
    end

`ifdef EEA_ZERO_CHECK_EN
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (state_q == IDLE && start) zero_q <= go_done;
            err <= (state_q == DONE) && zero_q;
        end
    end
`endif

endmodule

// File: tb/tb_eea_datapath.sv
// Directed bench for eea_datapath: m=7 and m=3 instances, each driven by a small control unit.
module tb_eea_datapath;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start7 = 1'b0, sw7, rd7, mr7, mu7;
    logic [6:0] a7 = '0;
    logic [7:0] f7 = 8'h83;
    logic       rm7, sm7, busy7, done7, err7;
    logic [6:0] res7;

    logic       start3 = 1'b0, sw3, rd3, mr3, mu3;
    logic [2:0] a3 = '0;
    logic [3:0] f3 = 4'hB;
    logic       rm3, sm3, busy3, done3, err3;
    logic [2:0] res3;

    eea_datapath #(.m(7)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7), .a_in(a7), .f_in(f7),
        .switch_i(sw7), .reduce_i(rd7), .multr_i(mr7), .multu_i(mu7),
        .rm(rm7), .sm(sm7), .busy(busy7), .done(done7), .result(res7), .err(err7)
    );

    eea_datapath #(.m(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a3), .f_in(f3),
        .switch_i(sw3), .reduce_i(rd3), .multr_i(mr3), .multu_i(mu3),
        .rm(rm3), .sm(sm3), .busy(busy3), .done(done3), .result(res3), .err(err3)
    );

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Brunner-style decision: returns {reduce, multr, switch, multu}
    function automatic logic [3:0] decide(input logic r, input logic s, input int d, output int dn);
        if (!r) begin
            dn = d + 1;
            return 4'b0101;
        end
        if (d == 0) begin
            dn = 1;
            return {s, 3'b011};
        end
        dn = d - 1;
        return {s, 3'b000};
    endfunction

    // Decisions are driven only in the APPLY half; garbage elsewhere must be ignored.
    int ph7 = 0, d7 = 0, dn7;
    always @(negedge clk) begin
        if (busy7 && ph7 == 1) begin
            {rd7, mr7, sw7, mu7} = decide(rm7, sm7, d7, dn7);
            d7  = dn7;
            ph7 = 0;
        end else begin
            {rd7, mr7, sw7, mu7} = 4'($urandom);
            if (busy7) ph7 = 1;
            else begin ph7 = 0; d7 = 0; end
        end
    end

    int ph3 = 0, d3 = 0, dn3;
    always @(negedge clk) begin
        if (busy3 && ph3 == 1) begin
            {rd3, mr3, sw3, mu3} = decide(rm3, sm3, d3, dn3);
            d3  = dn3;
            ph3 = 0;
        end else begin
            {rd3, mr3, sw3, mu3} = 4'($urandom);
            if (busy3) ph3 = 1;
            else begin ph3 = 0; d3 = 0; end
        end
    end

    task automatic run(input bit sel, input logic [6:0] a, input logic [6:0] exp,
                       input int exp_lat, input logic exp_err, input int mid, input string tag);
        int lat, nd;
        logic [6:0] r;
        logic e;
        lat = 0; nd = 0; r = '0; e = 1'b0;
        @(negedge clk);
        if (sel) begin a3 = a[2:0]; start3 = 1'b1; end
        else     begin a7 = a;      start7 = 1'b1; end
        @(posedge clk); #1;
        start3 = 1'b0;
        start7 = 1'b0;
        for (int i = 1; i <= exp_lat + 12; i++) begin
            @(posedge clk); #1;
            if (sel ? done3 : done7) begin
                nd++;
                if (lat == 0) begin
                    lat = i;
                    r = sel ? {4'b0, res3} : res7;
                    e = sel ? err3 : err7;
                end
            end
            if (!sel) start7 = (i == mid);
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " done count"}, nd, 1);
        chk({tag, " result"}, r, exp);
        chk({tag, " err"}, e, exp_err);
        chk({tag, " result hold"}, sel ? {4'b0, res3} : res7, exp);
    endtask

    localparam logic [2:0] INV3 [1:7] = '{3'd1, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3, 3'd4};

    initial begin
        int t1, t2, nd;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy7, 0);
        chk("reset done", done7, 0);
        chk("reset result", res7, 0);
        chk("reset err", err7, 0);
        chk("reset rm", rm7, 0);
        chk("reset sm", sm7, 0);
        chk("reset result m3", res3, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 7'h02, 7'h41, 29, 1'b0, 0, "a=02");
        run(1'b0, 7'h01, 7'h01, 29, 1'b0, 0, "a=01");
        run(1'b0, 7'h41, 7'h02, 29, 1'b0, 0, "a=41");
        run(1'b0, 7'h02, 7'h41, 29, 1'b0, 12, "mid start");
`ifdef EEA_ZERO_CHECK_EN
        run(1'b0, 7'h00, 7'h00, 1, 1'b1, 0, "zero");
`else
        run(1'b0, 7'h00, 7'h05, 29, 1'b0, 0, "zero");
`endif
        run(1'b0, 7'h03, 7'h7E, 29, 1'b0, 0, "a=03");

        // start held high: second run accepted on the IDLE cycle after done
        t1 = 0; t2 = 0;
        @(negedge clk);
        a7 = 7'h03;
        start7 = 1'b1;
        for (int i = 0; i <= 80 && t2 == 0; i++) begin
            @(posedge clk); #1;
            if (done7) begin
                if (t1 == 0) t1 = i;
                else t2 = i;
            end
        end
        start7 = 1'b0;
        chk("held start first done", t1, 29);
        chk("held start second done", t2, 59);
        chk("held start result", res7, 7'h7E);

        // reset during the 10th APPLY
        @(negedge clk);
        a7 = 7'h02;
        start7 = 1'b1;
        @(posedge clk); #1;
        start7 = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            @(posedge clk); #1;
        end
        chk("abort busy before", busy7, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy7, 0);
        chk("abort result", res7, 0);
        chk("abort done", done7, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done7) nd++;
        end
        chk("abort no done", nd, 0);
        run(1'b0, 7'h02, 7'h41, 29, 1'b0, 0, "after abort");

        for (int a = 1; a <= 7; a++) begin
            logic [2:0] av;
            av = 3'(a);
            run(1'b1, {4'b0, av}, {4'b0, INV3[a]}, 13, 1'b0, 0, $sformatf("m3 a=%0d", a));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/eea_datapath.md
EEA_DATAPATH -- requirements
Module: eea_datapath

Interface
REQ-001 SHALL have parameter m, default 7: field degree; operands are m bits and the modulus is m+1 bits.
REQ-002 SHALL have parameter BITS, default $clog2(2*m+1): width of the iteration counter.
REQ-003 SHALL have clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have start  input  1  request to begin an inversion; sampled only in IDLE.
REQ-006 SHALL have a_in  input  m  operand A(x), captured on an accepted start.
REQ-007 SHALL have f_in  input  m+1  irreducible modulus F(x), with f_in[m]=1 and f_in[0]=1; captured on an accepted start.
REQ-008 SHALL have switch_i, reduce_i, multr_i, multu_i  input  1 each  registered control decisions from the control unit.
REQ-009 SHALL have rm  output  1  R[m], driven combinationally from the R register.
REQ-010 SHALL have sm  output  1  S[m], driven combinationally from the S register.
REQ-011 SHALL have busy  output  1  high in the EVAL and APPLY states.
REQ-012 SHALL have done  output  1  one-cycle completion pulse.
REQ-013 SHALL have result  output  m  inverse A^-1 mod F, held stable until the next accepted start.
REQ-014 SHALL have err  output  1  zero-operand flag, valid while done is high.

Function
REQ-015 SHALL implement the FSM states IDLE, EVAL, APPLY and DONE; each state occupies one cycle, except IDLE, which waits for start.
REQ-016 IDLE with start=1 SHALL load R={1'b0,a_in}, S=f_in, U=1, V=0 and cnt=0, then go to EVAL.
REQ-017 EVAL SHALL hold all registers unchanged so that the control unit can register decisions from rm and sm; EVAL SHALL then go to APPLY.
REQ-018 APPLY SHALL update the registers from the control inputs sampled at that edge, in the order of REQ-019 to REQ-022.
REQ-019 If reduce_i=1: S=S^R and V=V^U (GF(2) subtraction).
REQ-020 If multr_i=1: R=R<<1 (width m+1). If multr_i=0: S=S<<1 (width m+1), applied after the reduce step.
REQ-021 If switch_i=1: exchange R and S, and exchange U and V, using the values produced by REQ-019 and REQ-020.
REQ-022 If multu_i=1: U=x*U mod F, i.e. the shift-out bit selects XOR with f_in[m-1:0]. If multu_i=0: U=U/x mod F, i.e. if U[0]=1 then U=((U^F[m-1:0])>>1) with bit m-1 set to 1, else U=U>>1.
REQ-023 Each APPLY SHALL increment cnt; after the APPLY in which cnt reaches 2m, the FSM SHALL go to DONE, otherwise back to EVAL.
REQ-024 DONE SHALL assert done for exactly one cycle, load result from U, and return to IDLE.
REQ-025 Latency: if start is accepted at edge 0, done SHALL be visible after edge 4m+1 (29 cycles for m=7).
REQ-026 start asserted while not in IDLE SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-027 start held high through DONE SHALL be accepted on the first IDLE cycle that follows.
REQ-028 Control inputs SHALL be ignored in every state other than APPLY.
REQ-029 All register arithmetic SHALL be carry-free XOR; the R and S registers SHALL be m+1 bits wide and the U and V registers m bits wide.

Reset
REQ-030 On rst_n=0, the FSM SHALL go to IDLE immediately and asynchronously; R, S, U, V, cnt, result, done, err and busy SHALL all be cleared to 0.
REQ-031 A reset during EVAL or APPLY SHALL abort the operation with no done pulse, and result SHALL read 0.
REQ-032 The first start after rst_n deasserts SHALL be accepted in the next cycle.

Configuration
REQ-033 Macro EEA_ZERO_CHECK_EN, when defined: a start accepted with a_in=0 SHALL go directly to DONE and assert done and err one cycle later, with result=0.
REQ-034 Macro EEA_ZERO_CHECK_EN, when undefined: err SHALL be tied to 0, a_in=0 SHALL run the full 2m iterations, and result SHALL be whatever U holds.

Verification
REQ-035 m=7, f_in=8'h83, a_in=7'h02, start pulse -> after 29 cycles done=1 and result=7'h41.
REQ-036 m=7, f_in=8'h83, a_in=7'h01 -> result=7'h01; then a_in=7'h41 -> result=7'h02.
REQ-037 Second start pulse asserted mid-run -> only one done pulse, and the result is unchanged from the single-start case.
REQ-038 rst_n pulled low during the 10th APPLY -> busy=0 and result=0 immediately, no done pulse; a new start completes correctly.
REQ-039 With EEA_ZERO_CHECK_EN defined, a_in=0 -> done=1 and err=1 one cycle after start, with result=0.
REQ-040 m=3, f_in=4'hB, exhaustive a_in=1..7 -> result multiplied by a_in, reduced mod F, equals 1 in every case.
